// File: rtl/ccff_chain_loader_if.sv
// Load-word stream, configuration-chain pins and tail-readback stream of the chain loader.
// The loader takes the slave view; the environment (fabric, data source, readback sink) takes the master view.
interface ccff_chain_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] ccff_head;
  logic       ccff_shift_en;
  logic [7:0] ccff_tail;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;

  modport slave (
    input  in_valid, in_data, ccff_tail, rd_ready,
    output in_ready, ccff_head, ccff_shift_en, rd_valid, rd_data
  );

  modport master (
    output in_valid, in_data, ccff_tail, rd_ready,
    input  in_ready, ccff_head, ccff_shift_en, rd_valid, rd_data
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: shifts CHAIN_LEN words into eight scan chains, holds
// config_enable for SETTLE cycles afterwards, and optionally streams the bits leaving the chain tails.

module ccff_chain_loader_chk #(
  parameter int CHAIN_LEN = 1024
) (
  input logic        clk,
  input logic        rst_n,
  input logic        in_valid,
  input logic        in_ready,
  input logic        shift_en,
  input logic        rd_valid,
  input logic        busy,
  input logic        config_enable,
  input logic [15:0] shift_cnt
);
  localparam logic [15:0] LEN_C = 16'(CHAIN_LEN);

  a_rd_needs_shift: assert property (@(posedge clk) disable iff (!rst_n) rd_valid |-> shift_en);
  a_shift_is_hs:    assert property (@(posedge clk) disable iff (!rst_n) shift_en |-> (in_valid && in_ready));
  a_cnt_bounded:    assert property (@(posedge clk) disable iff (!rst_n) shift_cnt <= LEN_C);
  a_busy_cfg:       assert property (@(posedge clk) disable iff (!rst_n) busy == config_enable);
endmodule

module ccff_chain_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int SETTLE    = 2
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic                start,
  input  logic                abort,
  input  logic                readback_en,
  ccff_chain_loader_if.slave  bus,
  output logic                config_enable,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [15:0]         shift_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [15:0] LAST_SHIFT_C  = 16'(CHAIN_LEN - 1);
  localparam logic [3:0]  LAST_SETTLE_C = 4'(SETTLE - 1);

  state_t      state_r;
  logic [15:0] shift_cnt_r;
  logic [3:0]  settle_cnt_r;
  logic        rb_r;
  logic        done_r;
  logic        aborted_r;
  logic        config_enable_r;
  logic        busy_r;

  logic        in_ready_s;
  logic        shift_s;
  logic [7:0]  head_s;
  logic        rd_valid_s;
  logic [7:0]  rd_data_s;

  // Handshake and chain drive; the chains capture on the same edge that accepts the word.
  always_comb begin
    in_ready_s = 1'b0;
    shift_s    = 1'b0;
    head_s     = 8'd0;
    rd_valid_s = 1'b0;
    rd_data_s  = 8'd0;
    if (state_r == ST_LOAD) begin
      in_ready_s = !rb_r || bus.rd_ready;
    end else begin
      in_ready_s = 1'b0;
    end
    shift_s    = in_ready_s && bus.in_valid;
    // Head is forced low during reset so the chains see a quiet input.
    if (prog_reset) begin
      head_s = bus.in_data;
    end else begin
      head_s = 8'd0;
    end
    rd_valid_s = shift_s && rb_r;
    if (rd_valid_s) begin
      rd_data_s = bus.ccff_tail;
    end else begin
      rd_data_s = 8'd0;
    end
  end

  // Load sequencer with registered status outputs.
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      state_r         <= ST_IDLE;
      shift_cnt_r     <= 16'd0;
      settle_cnt_r    <= 4'd0;
      rb_r            <= 1'b0;
      done_r          <= 1'b0;
      aborted_r       <= 1'b0;
      config_enable_r <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r         <= ST_LOAD;
            rb_r            <= readback_en;
            shift_cnt_r     <= 16'd0;
            settle_cnt_r    <= 4'd0;
            done_r          <= 1'b0;
            aborted_r       <= 1'b0;
            config_enable_r <= 1'b1;
            busy_r          <= 1'b1;
          end
        end
        ST_LOAD: begin
          // A shift coinciding with abort still counts.
          if (shift_s) begin
            shift_cnt_r <= shift_cnt_r + 16'd1;
          end
          if (abort) begin
            state_r         <= ST_IDLE;
            aborted_r       <= 1'b1;
            config_enable_r <= 1'b0;
            busy_r          <= 1'b0;
          end else if (shift_s && (shift_cnt_r == LAST_SHIFT_C)) begin
            state_r      <= ST_SETTLE;
            settle_cnt_r <= 4'd0;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state_r         <= ST_IDLE;
            aborted_r       <= 1'b1;
            config_enable_r <= 1'b0;
            busy_r          <= 1'b0;
          end else if (settle_cnt_r == LAST_SETTLE_C) begin
            state_r         <= ST_DONE;
            done_r          <= 1'b1;
            config_enable_r <= 1'b0;
            busy_r          <= 1'b0;
          end else begin
            settle_cnt_r <= settle_cnt_r + 4'd1;
          end
        end
        default: begin
          state_r         <= ST_IDLE;
          config_enable_r <= 1'b0;
          busy_r          <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_s;
  assign bus.ccff_shift_en = shift_s;
  assign bus.ccff_head     = head_s;
  assign bus.rd_valid      = rd_valid_s;
  assign bus.rd_data       = rd_data_s;

  assign config_enable = config_enable_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign aborted       = aborted_r;
  assign shift_cnt     = shift_cnt_r;

  ccff_chain_loader_chk #(.CHAIN_LEN(CHAIN_LEN)) u_chk (
    .clk           (prog_clk),
    .rst_n         (prog_reset),
    .in_valid      (bus.in_valid),
    .in_ready      (in_ready_s),
    .shift_en      (shift_s),
    .rd_valid      (rd_valid_s),
    .busy          (busy_r),
    .config_enable (config_enable_r),
    .shift_cnt     (shift_cnt_r)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a fabric chain model feeds ccff_tail and a scoreboard
// queue holds the expected readback words.
module tb_ccff_chain_loader;
  localparam int CHAIN_LEN = 4;
  localparam int SETTLE    = 2;

  logic        prog_clk    = 1'b0;
  logic        prog_reset  = 1'b0;
  logic        start       = 1'b0;
  logic        abort       = 1'b0;
  logic        readback_en = 1'b0;
  logic        config_enable;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] shift_cnt;

  int          checks  = 0;
  int          errors  = 0;
  int          exp_cnt = 0;
  int          cfg_hi  = 0;
  int          rd_cnt  = 0;
  logic        rb_m    = 1'b0;
  logic [7:0]  sb_q [$];
  logic [7:0]  chain_m [CHAIN_LEN] = '{8'hA3, 8'hA2, 8'hA1, 8'hA0};

  ccff_chain_loader_if bus ();

  ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .SETTLE(SETTLE)) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .start         (start),
    .abort         (abort),
    .readback_en   (readback_en),
    .bus           (bus),
    .config_enable (config_enable),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .shift_cnt     (shift_cnt)
  );

  always #5 prog_clk = ~prog_clk;

  // Fabric model: eight chains of CHAIN_LEN stages, stage 0 at the head.
  always @(posedge prog_clk) begin
    if (bus.ccff_shift_en) begin
      for (int i = CHAIN_LEN - 1; i > 0; i--) chain_m[i] <= chain_m[i-1];
      chain_m[0] <= bus.ccff_head;
    end
  end
  assign bus.ccff_tail = chain_m[CHAIN_LEN-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, check combinational outputs, then the registered count.
  task automatic cyc(input logic v, input logic [7:0] d, input logic rr, input logic exp_rdy);
    logic exp_shift;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.rd_ready = rr;
    #1;
    exp_shift = v & exp_rdy;
    if (config_enable) cfg_hi++;
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("shift_en", bus.ccff_shift_en, exp_shift);
    chk("head", bus.ccff_head, d);
    if (exp_shift && rb_m) sb_q.push_back(bus.ccff_tail);
    chk("rd_valid", bus.rd_valid, exp_shift & rb_m);
    if (bus.rd_valid) begin
      rd_cnt++;
      checks++;
      assert (sb_q.size() > 0) else begin
        errors++;
        $error("FAIL rd_extra observed=unexpected word expected=none");
      end
      if (sb_q.size() > 0) chk("rd_data", bus.rd_data, sb_q.pop_front());
    end
    if (exp_shift) exp_cnt++;
    @(posedge prog_clk); #1;
    chk("shift_cnt", shift_cnt, exp_cnt);
  endtask

  task automatic pulse_start(input logic rb);
    bus.in_valid = 1'b0;
    start        = 1'b1;
    readback_en  = rb;
    @(posedge prog_clk); #1;
    start   = 1'b0;
    rb_m    = rb;
    exp_cnt = 0;
    rd_cnt  = 0;
    cfg_hi  = 0;
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    bus.rd_ready = 1'b1;
    #12;
    chk("rst_cfg", config_enable, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", bus.in_ready, 1'b0);
    chk("rst_shift", bus.ccff_shift_en, 1'b0);
    chk("rst_rdv", bus.rd_valid, 1'b0);
    chk("rst_head", bus.ccff_head, 8'h00);
    chk("rst_done", done, 1'b0);
    chk("rst_cnt", shift_cnt, 16'd0);
    @(negedge prog_clk);
    prog_reset = 1'b1;
    @(posedge prog_clk); #1;

    // Full load, no readback.
    pulse_start(1'b0);
    chk("ld_cfg", config_enable, 1'b1);
    chk("ld_busy", busy, 1'b1);
    chk("ld_done", done, 1'b0);
    cyc(1'b1, 8'h01, 1'b1, 1'b1);
    cyc(1'b1, 8'h02, 1'b1, 1'b1);
    cyc(1'b1, 8'h04, 1'b1, 1'b1);
    cyc(1'b1, 8'h08, 1'b1, 1'b1);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("ld_cfg_cycles", cfg_hi, 6);
    chk("ld_done_hi", done, 1'b1);
    chk("ld_cfg_off", config_enable, 1'b0);
    chk("ld_busy_off", busy, 1'b0);
    chk("ld_chain_head", chain_m[0], 8'h08);
    chk("ld_chain_tail", chain_m[CHAIN_LEN-1], 8'h01);

    // Abort in DONE is ignored.
    abort = 1'b1;
    @(posedge prog_clk); #1;
    abort = 1'b0;
    chk("dn_abort_ign", aborted, 1'b0);
    chk("dn_done_hold", done, 1'b1);

    // Start from DONE, bubbles, ignored starts in LOAD and SETTLE.
    pulse_start(1'b0);
    chk("bb_done_clr", done, 1'b0);
    cyc(1'b1, 8'h10, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    start = 1'b1;
    cyc(1'b1, 8'h20, 1'b1, 1'b1);
    start = 1'b0;
    chk("bb_cfg", config_enable, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 8'h30, 1'b1, 1'b1);
    chk("bb_not_done", done, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 8'h40, 1'b1, 1'b1);
    start = 1'b1;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    start = 1'b0;
    chk("st_ign_cfg", config_enable, 1'b1);
    chk("st_ign_done", done, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("bb_done", done, 1'b1);

    // Readback with a three-cycle rd_ready stall.
    pulse_start(1'b1);
    cyc(1'b1, 8'h11, 1'b1, 1'b1);
    cyc(1'b1, 8'h22, 1'b1, 1'b1);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b1, 1'b1);
    cyc(1'b1, 8'h44, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rb_done", done, 1'b1);
    chk("rb_count", rd_cnt, CHAIN_LEN);
    chk("rb_sb_empty", sb_q.size(), 0);

    // Abort coinciding with the third shift.
    pulse_start(1'b0);
    cyc(1'b1, 8'h5A, 1'b1, 1'b1);
    cyc(1'b1, 8'h5B, 1'b1, 1'b1);
    abort = 1'b1;
    cyc(1'b1, 8'h5C, 1'b1, 1'b1);
    abort = 1'b0;
    chk("ab_aborted", aborted, 1'b1);
    chk("ab_cfg", config_enable, 1'b0);
    chk("ab_busy", busy, 1'b0);
    chk("ab_done", done, 1'b0);
    cyc(1'b1, 8'h66, 1'b1, 1'b0);
    abort = 1'b1;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ab_idle_cfg", config_enable, 1'b0);

    // Start and abort together in IDLE: start wins.
    pulse_start(1'b0);
    abort = 1'b0;
    chk("sa_aborted_clr", aborted, 1'b0);
    chk("sa_cfg", config_enable, 1'b1);
    chk("sa_cnt", shift_cnt, 16'd0);

    // Reset in the middle of the load.
    cyc(1'b1, 8'h71, 1'b1, 1'b1);
    cyc(1'b1, 8'h72, 1'b1, 1'b1);
    cyc(1'b1, 8'h73, 1'b1, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hF0;
    prog_reset   = 1'b0;
    #1;
    chk("mr_cfg", config_enable, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_ready", bus.in_ready, 1'b0);
    chk("mr_shift", bus.ccff_shift_en, 1'b0);
    chk("mr_rdv", bus.rd_valid, 1'b0);
    chk("mr_head", bus.ccff_head, 8'h00);
    chk("mr_cnt", shift_cnt, 16'd0);
    @(negedge prog_clk);
    prog_reset = 1'b1;
    @(posedge prog_clk); #1;
    exp_cnt = 0;
    rb_m    = 1'b0;
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    chk("mr_idle_cfg", config_enable, 1'b0);
    pulse_start(1'b0);
    chk("mr_fresh_cnt", shift_cnt, 16'd0);
    cyc(1'b1, 8'h81, 1'b1, 1'b1);
    cyc(1'b1, 8'h82, 1'b1, 1'b1);
    cyc(1'b1, 8'h83, 1'b1, 1'b1);
    cyc(1'b1, 8'h84, 1'b1, 1'b1);
    cyc(1'b1, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h00, 1'b1, 1'b0);
    chk("mr_done", done, 1'b1);
    chk("mr_final_cnt", shift_cnt, 16'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
